// File: rtl/led_strip_pkg.sv
// -----------------------------------------------------------------------------
// led_strip_pkg
// Shared types and helpers for the serial LED strip driver.
//   state_t        : transmit FSM states (IDLE, HIGH, LOW, LATCH)
//   pixel_t        : 24-bit GRB pixel word, G in [23:16], R in [15:8], B in [7:0]
//   *_MSB / *_LSB  : channel bit positions inside pixel_t
//   scale_pixel()  : per-channel brightness scaling, (c * mult) >> 8
// -----------------------------------------------------------------------------
package led_strip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    typedef logic [23:0] pixel_t;

    localparam int G_MSB = 23;
    localparam int G_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    // mult is brightness+1 (1..256), so 256 leaves the channel untouched.
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [8:0] mult);
        return 8'((17'(c) * 17'(mult)) >> 8);
    endfunction

    function automatic pixel_t scale_pixel(input pixel_t p, input logic [8:0] mult);
        return {scale_channel(p[G_MSB:G_LSB], mult),
                scale_channel(p[R_MSB:R_LSB], mult),
                scale_channel(p[B_MSB:B_LSB], mult)};
    endfunction

endpackage

// File: rtl/led_bit_timer.sv
// -----------------------------------------------------------------------------
// led_bit_timer
// Phase timing for one serial bit: a '1' is L_TIME high then S_TIME low, a '0'
// is S_TIME high then L_TIME low.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : counting enabled (FSM in HIGH or LOW); counter held at 0 otherwise
//   bit_val    : value of the bit being sent
//   low_phase  : 0 = high phase, 1 = low phase
//   phase_end  : last cycle of the current phase
//   bit_done   : last cycle of the whole bit (end of the low phase)
// -----------------------------------------------------------------------------
module led_bit_timer #(
    parameter int L_TIME = 80,
    parameter int S_TIME = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic bit_val,
    input  logic low_phase,
    output logic phase_end,
    output logic bit_done
);

    logic [15:0] cnt_reg;
    logic [15:0] phase_len;

    // Long phase is the high phase of a '1' or the low phase of a '0'.
    always_comb begin
        phase_len = (bit_val ^ low_phase) ? 16'(L_TIME) : 16'(S_TIME);
    end

    assign phase_end = en && (cnt_reg == phase_len - 16'd1);
    assign bit_done  = phase_end && low_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!en || phase_end) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

endmodule

// File: rtl/led_strip_driver.sv
// -----------------------------------------------------------------------------
// led_strip_driver
// Pixel buffer plus serial transmitter for a single-wire LED strip.
// Optional feature macro: LED_STRIP_BRIGHTNESS_EN (global brightness scaling,
// sampled at frame start). Without it the brightness port is ignored.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   wr_en/addr/data : pixel write port, accepted in every state, out-of-range
//                     addresses dropped
//   start           : frame request, honoured only in IDLE
//   brightness      : global scale (feature build only)
//   busy            : frame in progress (drops together with frame_done)
//   frame_done      : one-cycle pulse in the last latch cycle
//   led_stripe_pin  : registered serial data line
// -----------------------------------------------------------------------------
module led_strip_driver
    import led_strip_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int L_TIME = 80,
    parameter int S_TIME = 40,
    parameter int R_TIME = 5000,
    parameter int AW     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          start,
    input  logic [7:0]    brightness,
    output logic          busy,
    output logic          frame_done,
    output logic          led_stripe_pin
);

    localparam logic [AW-1:0] LAST_PIX   = AW'(N_LEDS - 1);
    localparam logic [15:0]   R_LAST     = 16'(R_TIME - 1);
    localparam logic [15:0]   R_PRE      = 16'(R_TIME - 2);
    localparam logic          SHORT_LTCH = (R_TIME == 1);

    state_t        state_reg;
    pixel_t        shift_reg;
    logic [4:0]    bit_idx_reg;
    logic [AW-1:0] pix_idx_reg;
    logic [AW-1:0] pix_idx_next;
    logic [15:0]   latch_cnt_reg;
    pixel_t        pix_reg [N_LEDS];
    pixel_t        fetch_data;
    pixel_t        first_word;
    pixel_t        next_word;
    logic          phase_end;
    logic          bit_done;

    // Pixel storage: one word register per pixel, written when its address matches.
    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_pix
            pixel_t word_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    word_reg <= wr_data;
                end
            end
            assign pix_reg[gi] = word_reg;
        end
    endgenerate

    assign pix_idx_next = pix_idx_reg + AW'(1);

    // Read mux for the next pixel; storage updates on the same edge are not seen.
    always_comb begin
        fetch_data = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (pix_idx_next == AW'(i)) begin
                fetch_data = pix_reg[i];
            end
        end
    end

`ifdef LED_STRIP_BRIGHTNESS_EN
    logic [7:0] bright_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            bright_reg <= brightness;
        end
    end

    // Pixel 0 loads on the start edge, before bright_reg holds the sample.
    assign first_word = scale_pixel(pix_reg[0], {1'b0, brightness} + 9'd1);
    assign next_word  = scale_pixel(fetch_data, {1'b0, bright_reg} + 9'd1);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign first_word = pix_reg[0];
    assign next_word  = fetch_data;
`endif

    led_bit_timer #(
        .L_TIME(L_TIME),
        .S_TIME(S_TIME)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       ((state_reg == HIGH) || (state_reg == LOW)),
        .bit_val  (shift_reg[23]),
        .low_phase(state_reg == LOW),
        .phase_end(phase_end),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            pix_idx_reg    <= '0;
            latch_cnt_reg  <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            led_stripe_pin <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg      <= first_word;
                        bit_idx_reg    <= '0;
                        pix_idx_reg    <= '0;
                        busy           <= 1'b1;
                        led_stripe_pin <= 1'b1;
                        state_reg      <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        led_stripe_pin <= 1'b0;
                        state_reg      <= LOW;
                    end
                end
                LOW: begin
                    if (bit_done) begin
                        if (bit_idx_reg == 5'd23) begin
                            bit_idx_reg <= '0;
                            if (pix_idx_reg == LAST_PIX) begin
                                pix_idx_reg   <= '0;
                                latch_cnt_reg <= '0;
                                // A one-cycle latch is itself the frame_done cycle.
                                frame_done    <= SHORT_LTCH;
                                busy          <= !SHORT_LTCH;
                                state_reg     <= LATCH;
                            end else begin
                                pix_idx_reg    <= pix_idx_next;
                                shift_reg      <= next_word;
                                led_stripe_pin <= 1'b1;
                                state_reg      <= HIGH;
                            end
                        end else begin
                            bit_idx_reg    <= bit_idx_reg + 5'd1;
                            shift_reg      <= {shift_reg[22:0], 1'b0};
                            led_stripe_pin <= 1'b1;
                            state_reg      <= HIGH;
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt_reg == R_LAST) begin
                        latch_cnt_reg <= '0;
                        state_reg     <= IDLE;
                    end else begin
                        latch_cnt_reg <= latch_cnt_reg + 16'd1;
                        // Flag the final latch cycle; the FSM is still in LATCH then,
                        // so a start in the frame_done cycle is ignored.
                        if (latch_cnt_reg == R_PRE) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_strip_driver.sv
// -----------------------------------------------------------------------------
// tb_led_strip_driver
// Self-checking bench for led_strip_driver with N_LEDS=2, L_TIME=4, S_TIME=2,
// R_TIME=20. The expected pin waveform of each frame is built from the pixel
// values as a list of high/low cycles and compared cycle by cycle together with
// busy and frame_done.
// -----------------------------------------------------------------------------
module tb_led_strip_driver;

    localparam int N_LEDS  = 2;
    localparam int L_TIME  = 4;
    localparam int S_TIME  = 2;
    localparam int R_TIME  = 20;
    localparam int AW      = 2;
    localparam int PIX_CYC = 24 * (L_TIME + S_TIME);
    localparam int BIT_CYC = N_LEDS * PIX_CYC;
    localparam int FRAME   = BIT_CYC + R_TIME;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          start = 1'b0;
    logic [7:0]    brightness = 8'hFF;
    logic          busy;
    logic          frame_done;
    logic          led_stripe_pin;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] model_pix [N_LEDS];

    led_strip_driver #(
        .N_LEDS(N_LEDS),
        .L_TIME(L_TIME),
        .S_TIME(S_TIME),
        .R_TIME(R_TIME),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .brightness    (brightness),
        .busy          (busy),
        .frame_done    (frame_done),
        .led_stripe_pin(led_stripe_pin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef LED_STRIP_BRIGHTNESS_EN
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        int v;
        v = (int'(c) * (int'(b) + 1)) / 256;
        return v[7:0];
    endfunction
`endif

    task automatic apply_reset(input string tag);
        rst   = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        check($sformatf("%s in_reset", tag), {29'd0, led_stripe_pin, busy, frame_done}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < N_LEDS; k++) model_pix[k] = '0;
        repeat (3) begin
            @(negedge clk);
            check($sformatf("%s idle", tag), {29'd0, led_stripe_pin, busy, frame_done}, 32'd0);
        end
        $display("reset %s released", tag);
    endtask

    task automatic write_pix(input logic [AW-1:0] a, input logic [23:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (int'(a) < N_LEDS) model_pix[a] = d;
        $display("write addr=%0d data=%06h", a, d);
    endtask

    // One frame: start at relative cycle 0, stray starts at cycle 10 and in the
    // frame_done cycle, optional write at wr_at, optional reset at rst_at.
    task automatic run_frame(input string tag, input logic [7:0] bri, input int wr_at,
                             input logic [AW-1:0] w_a, input logic [23:0] w_d, input int rst_at);
        logic [23:0] sent [N_LEDS];
        bit          wave [$];
        logic [2:0]  want;
        int          fd_seen;
        bit          aborted;
        int          lim;

        // A pixel is fetched on the edge ending cycle k*PIX_CYC; a write on
        // that same edge is too late for it.
        for (int k = 0; k < N_LEDS; k++) begin
            sent[k] = model_pix[k];
            if (wr_at >= 0 && int'(w_a) == k && wr_at < k * PIX_CYC) sent[k] = w_d;
`ifdef LED_STRIP_BRIGHTNESS_EN
            sent[k] = {scale_ch(sent[k][23:16], bri), scale_ch(sent[k][15:8], bri),
                       scale_ch(sent[k][7:0], bri)};
`endif
            for (int b = 23; b >= 0; b--) begin
                lim = sent[k][b] ? L_TIME : S_TIME;
                for (int t = 0; t < L_TIME + S_TIME; t++) wave.push_back(t < lim);
            end
        end

        fd_seen = 0;
        aborted = 1'b0;
        for (int r = 0; r <= FRAME + 2; r++) begin
            @(negedge clk);
            want[2] = 1'b0;
            if (r >= 1 && r <= BIT_CYC) want[2] = wave[r-1];
            want[1] = (r >= 1 && r < FRAME);
            want[0] = (r == FRAME);
            check($sformatf("%s pin/busy/done r%0d", tag, r),
                  {29'd0, led_stripe_pin, busy, frame_done}, {29'd0, want});
            if (frame_done) fd_seen++;
            if (r == rst_at) begin
                start = 1'b0;
                wr_en = 1'b0;
                rst   = 1'b1;
                #1;
                check($sformatf("%s abort r%0d", tag, r),
                      {29'd0, led_stripe_pin, busy, frame_done}, 32'd0);
                aborted = 1'b1;
                break;
            end
            start      = (r == 0) || (r == 10) || (r == FRAME);
            brightness = (r == 0) ? bri : ~bri;
            wr_en      = (r == wr_at);
            wr_addr    = w_a;
            wr_data    = w_d;
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (!aborted) begin
            check($sformatf("%s done_count", tag), fd_seen, 1);
            if (wr_at >= 0 && int'(w_a) < N_LEDS) model_pix[w_a] = w_d;
        end
        $display("frame %s: pix0=%06h pix1=%06h bri=%0d %s", tag, sent[0], sent[1], bri,
                 aborted ? "aborted" : "complete");
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [23:0]   rd;
        logic [7:0]    rb;
        int            rw;

        apply_reset("por");

        write_pix(2'd0, 24'hFF0000);
        write_pix(2'd1, 24'h000001);
        run_frame("basic", 8'hFF, -1, 2'd0, 24'h0, -1);

        run_frame("wr_mid", 8'hFF, 50, 2'd1, 24'hAAAAAA, -1);
        run_frame("wr_at_fetch", 8'hFF, PIX_CYC, 2'd1, 24'h5A5A5A, -1);
        run_frame("wr_before_fetch", 8'hFF, PIX_CYC - 1, 2'd1, 24'hC3C3C3, -1);

        write_pix(2'd3, 24'h123456);
        run_frame("oob", 8'hFF, 77, 2'd2, 24'h654321, -1);

        run_frame("abort", 8'hFF, -1, 2'd0, 24'h0, 100);
        apply_reset("abort");
        run_frame("after_abort", 8'hFF, -1, 2'd0, 24'h0, -1);

`ifdef LED_STRIP_BRIGHTNESS_EN
        write_pix(2'd0, 24'hFF8002);
        write_pix(2'd1, 24'hFFFFFF);
        run_frame("bri127", 8'd127, -1, 2'd0, 24'h0, -1);
        run_frame("bri0", 8'd0, -1, 2'd0, 24'h0, -1);
`endif

        for (int it = 0; it < 5; it++) begin
            write_pix(2'd0, 24'($urandom));
            write_pix(2'd1, 24'($urandom));
            ra = AW'($urandom_range(3, 0));
            rd = 24'($urandom);
            rb = 8'($urandom);
            rw = int'($urandom_range(BIT_CYC, 0));
            run_frame($sformatf("rand%0d", it), rb, rw, ra, rd, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_strip_driver.md
LED_STRIP_DRIVER -- requirements
Module: led_strip_driver

Interface
REQ-001 The block SHALL have parameter N_LEDS, default 8: number of pixels in the strip, minimum 1.
REQ-002 The block SHALL have parameter L_TIME, default 80: long pulse phase in clk cycles, minimum 2.
REQ-003 The block SHALL have parameter S_TIME, default 40: short pulse phase in clk cycles, minimum 1, less than L_TIME.
REQ-004 The block SHALL have parameter R_TIME, default 5000: latch (reset-low) duration in clk cycles, minimum 1.
REQ-005 The block SHALL have parameter AW, default $clog2(N_LEDS) (minimum 1): pixel address width.
REQ-006 The block SHALL have port clk, input, width 1: single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-008 The block SHALL have port wr_en, input, width 1: pixel write strobe.
REQ-009 The block SHALL have port wr_addr, input, width AW: pixel index.
REQ-010 The block SHALL have port wr_data, input, width 24: GRB pixel word, G in bits [23:16].
REQ-011 The block SHALL have port start, input, width 1: frame transmit request.
REQ-012 The block SHALL have port brightness, input, width 8: global scale; used only when the macro is defined.
REQ-013 The block SHALL have port busy, output, width 1: high while a frame is in progress.
REQ-014 The block SHALL have port frame_done, output, width 1: one-cycle pulse at the end of a frame.
REQ-015 The block SHALL have port led_stripe_pin, output, width 1: registered serial data line.

Function
REQ-016 The FSM SHALL have states IDLE, HIGH, LOW and LATCH.
REQ-017 On wr_en with wr_addr < N_LEDS, the addressed pixel SHALL be updated the next cycle; writes with wr_addr >= N_LEDS SHALL be ignored.
REQ-018 Writes SHALL be accepted in every state.
REQ-019 In IDLE, start=1 SHALL load pixel 0 into a 24-bit shift register, assert busy and enter HIGH; led_stripe_pin SHALL rise on the next cycle.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Bits SHALL be sent MSB first, pixel 0 first.
REQ-022 A bit '1' SHALL be L_TIME cycles high, then S_TIME cycles low.
REQ-023 A bit '0' SHALL be S_TIME cycles high, then L_TIME cycles low.
REQ-024 The next pixel SHALL load in the last LOW cycle of bit 0, leaving no gap between pixels.
REQ-025 A fetch coinciding with a write to the same address SHALL use the old data.
REQ-026 After the last bit of pixel N_LEDS-1, the FSM SHALL enter LATCH with the pin low for R_TIME cycles.
REQ-027 At the end of LATCH, frame_done SHALL pulse for one cycle, busy SHALL drop in that same cycle, and the FSM SHALL return to IDLE.
REQ-028 The time from the start cycle to the frame_done cycle SHALL be N_LEDS*24*(L_TIME+S_TIME)+R_TIME cycles.
REQ-029 start asserted in the frame_done cycle SHALL be ignored; a new frame begins only on start asserted in IDLE.
REQ-030 Phase counters SHALL be 16 bits wide; the pixel index counter SHALL be AW bits wide; the bit index counter SHALL be 5 bits wide and wrap 23 -> 0.

Reset
REQ-031 While rst=1, led_stripe_pin, busy and frame_done SHALL be 0, the state SHALL be IDLE, all counters SHALL be 0 and all pixel storage SHALL be 0.
REQ-032 rst asserted mid-frame SHALL abort the frame immediately with no frame_done pulse.

Configuration
REQ-033 With LED_STRIP_BRIGHTNESS_EN defined, brightness SHALL be sampled at frame start and held for the whole frame.
REQ-034 With LED_STRIP_BRIGHTNESS_EN defined, each 8-bit channel c SHALL be sent as (c*(brightness+1))>>8, so 255 is identity and 0 gives all zeros.
REQ-035 Without LED_STRIP_BRIGHTNESS_EN, pixels SHALL be sent unscaled and the brightness port SHALL be ignored.

Structure
REQ-036 Package led_strip_pkg SHALL hold the FSM state typedef, the 24-bit pixel typedef and the channel bit positions.
REQ-037 Sub-module led_bit_timer SHALL generate the high/low phase timing for a single bit given bit value, L_TIME and S_TIME, and SHALL pulse when the bit completes.

Verification (bench parameters N_LEDS=2, L_TIME=4, S_TIME=2, R_TIME=20)
REQ-038 Write pix0=0xFF0000, pix1=0x000001, pulse start -> first 8 bits are 4 high/2 low, the next 39 bits are 2 high/4 low, the last bit is 4 high/2 low, then 20 cycles low, and frame_done fires 308 cycles after start.
REQ-039 Pulse start at cycle 10 of a frame -> no effect; frame_done fires exactly once, 308 cycles after the first start.
REQ-040 Write pix1=0xAAAAAA during pixel 0 transmission -> pixel 1 is sent as 0xAAAAAA.
REQ-041 Assert rst at cycle 100 of a frame -> pin, busy and frame_done read 0 the same cycle; a later start after rst is released begins a full 308-cycle frame.
REQ-042 With LED_STRIP_BRIGHTNESS_EN, brightness=127 and pix0=0xFF8002 -> sent as 0x7F4001; with brightness=0 -> sent as all zeros.
REQ-043 Write wr_addr=3 (out of range) with 0x123456 -> both pixels transmit unchanged.
